// File: rtl/glb_pkg.sv
// Shared types and constants for the GLB weight responder.
package glb_pkg;

  localparam int DEF_DATA_BITWIDTH     = 16;
  localparam int DEF_ADDR_BITWIDTH_GLB = 10;
  localparam int READ_LATENCY          = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_e;

endpackage

// File: rtl/glb_wght_responder_if.sv
// Fill and read-request bundle between loader/router and the weight bank.
interface glb_wght_responder_if #(
  parameter int DATA_BITWIDTH     = glb_pkg::DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH_GLB = glb_pkg::DEF_ADDR_BITWIDTH_GLB
);
  logic                         fill_start;
  logic [ADDR_BITWIDTH_GLB:0]   fill_len;
  logic [DATA_BITWIDTH-1:0]     fill_data;
  logic                         fill_valid;
  logic                         fill_done;
  logic                         busy;
  logic [ADDR_BITWIDTH_GLB-1:0] val_addr_read;
  logic                         val_req_read;
  logic [DATA_BITWIDTH-1:0]     val_data_o;
  logic                         val_enable_o;
  logic                         err_oob;
  logic                         err_ovf;

  modport slave (
    input  fill_start, fill_len, fill_data, fill_valid, val_addr_read, val_req_read,
    output fill_done, busy, val_data_o, val_enable_o, err_oob, err_ovf
  );

  modport master (
    output fill_start, fill_len, fill_data, fill_valid, val_addr_read, val_req_read,
    input  fill_done, busy, val_data_o, val_enable_o, err_oob, err_ovf
  );
endinterface

// File: rtl/glb_sram_1r1w.sv
// One-read/one-write weight array with a registered read port.
module glb_sram_1r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and its read register have no reset so they map onto SRAM macros; consumers gate rdata_o with their own valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/glb_wght_responder.sv
// GLB weight bank: sequential fill, one-entry pending slot, two-stage read pipeline.
module glb_wght_responder
  import glb_pkg::*;
#(
  parameter int DATA_BITWIDTH     = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH_GLB = DEF_ADDR_BITWIDTH_GLB
) (
  input logic                 clk,
  input logic                 reset,
  glb_wght_responder_if.slave bus
);
  localparam int LW = ADDR_BITWIDTH_GLB + 1;
  typedef logic [ADDR_BITWIDTH_GLB-1:0] addr_t;
  typedef logic [LW-1:0]                len_t;

  state_e state_q, state_d;
  len_t   wr_ptr_q, wr_ptr_d;
  len_t   loaded_len_q, loaded_len_d;
  logic   pend_vld_q, pend_vld_d;
  addr_t  pend_addr_q, pend_addr_d;
  logic   iss_vld_q, iss_vld_d;
  addr_t  iss_addr_q, iss_addr_d;
  logic   iss_oob_q, iss_oob_d;
  logic   rsp_vld_q, rsp_oob_q;
  logic   fill_done_q, fill_done_d;
  logic   err_oob_q, err_oob_d;
  logic   err_ovf_q, err_ovf_d;

  logic                     mem_we;
  logic [DATA_BITWIDTH-1:0] mem_rdata;

  glb_sram_1r1w #(
    .DATA_W(DATA_BITWIDTH),
    .ADDR_W(ADDR_BITWIDTH_GLB)
  ) u_sram (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q[ADDR_BITWIDTH_GLB-1:0]),
    .wdata_i(bus.fill_data),
    .re_i   (iss_vld_q),
    .raddr_i(iss_addr_q),
    .rdata_o(mem_rdata)
  );

  // NOTE: every always_comb output gets a default first, so no path can leave a value held and infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    loaded_len_d = loaded_len_q;
    pend_vld_d   = pend_vld_q;
    pend_addr_d  = pend_addr_q;
    iss_vld_d    = 1'b0;
    iss_addr_d   = iss_addr_q;
    iss_oob_d    = 1'b0;
    fill_done_d  = 1'b0;
    err_oob_d    = err_oob_q;
    err_ovf_d    = err_ovf_q;
    mem_we       = 1'b0;

    unique case (state_q)
      IDLE, READY: begin
        if (bus.fill_start) begin
          state_d      = FILL;
          wr_ptr_d     = '0;
          loaded_len_d = bus.fill_len;
          err_oob_d    = 1'b0;
          err_ovf_d    = 1'b0;
        end
      end
      FILL: begin
        if (bus.fill_valid && (wr_ptr_q != loaded_len_q)) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + len_t'(1);
        end
        if (wr_ptr_d == loaded_len_q) begin
          state_d     = READY;
          fill_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Parked request always goes first so responses stay in request order.
    if (state_q == READY) begin
      if (pend_vld_q) begin
        iss_vld_d  = 1'b1;
        iss_addr_d = pend_addr_q;
        pend_vld_d = bus.val_req_read;
        if (bus.val_req_read) pend_addr_d = bus.val_addr_read;
      end else if (bus.val_req_read) begin
        if (bus.fill_start) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = bus.val_addr_read;
        end else begin
          iss_vld_d  = 1'b1;
          iss_addr_d = bus.val_addr_read;
        end
      end
    end else if (bus.val_req_read) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = bus.val_addr_read;
      end else begin
        err_ovf_d = 1'b1;
      end
    end

    if (iss_vld_d) iss_oob_d = ({1'b0, iss_addr_d} >= loaded_len_q);
    if (iss_vld_q && iss_oob_q) err_oob_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      loaded_len_q <= '0;
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
      iss_vld_q    <= 1'b0;
      iss_addr_q   <= '0;
      iss_oob_q    <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_oob_q    <= 1'b0;
      fill_done_q  <= 1'b0;
      err_oob_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      loaded_len_q <= loaded_len_d;
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
      iss_vld_q    <= iss_vld_d;
      iss_addr_q   <= iss_addr_d;
      iss_oob_q    <= iss_oob_d;
      rsp_vld_q    <= iss_vld_q;
      rsp_oob_q    <= iss_oob_q;
      fill_done_q  <= fill_done_d;
      err_oob_q    <= err_oob_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign bus.busy         = (state_q == FILL);
  assign bus.fill_done    = fill_done_q;
  assign bus.val_enable_o = rsp_vld_q;
  assign bus.val_data_o   = (rsp_vld_q && !rsp_oob_q) ? mem_rdata : '0;
  assign bus.err_oob      = err_oob_q;
  assign bus.err_ovf      = err_ovf_q;
endmodule
